// File: rtl/multdiv_stall_ctrl_pkg.sv
// Shared definitions for the multdiv stall controller.
// Holds the FSM state encoding, the register-index type and the r0 constant.
// These are used by the controller, its hazard comparator and the bus interface.
package multdiv_stall_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Controller states: IDLE waits for a start, BUSY holds the pipeline
    // while the unit runs, DONE is the single write-back cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/multdiv_stall_ctrl_if.sv
// Pipeline <-> multdiv stall controller bus.
// master: the pipeline side. It drives the FD/DX decode fields, flush and the
//         multdiv unit handshake (md_rdy/md_exc), and receives the controls.
// slave : the controller. It receives decode/handshake and drives the
//         start pulses, freeze/bubble controls and the write-back select.
interface multdiv_stall_ctrl_if;
    import multdiv_stall_ctrl_pkg::*;

    reg_idx_t fd_rs;
    reg_idx_t fd_rt;
    logic     fd_uses_rt;
    reg_idx_t dx_rd;
    logic     dx_is_lw;
    logic     dx_is_mult;
    logic     dx_is_div;
    logic     flush;
    logic     md_rdy;
    logic     md_exc;

    logic     ctrl_mult;
    logic     ctrl_div;
    logic     stall_pc_fd;
    logic     stall_dx;
    logic     bubble_xm;
    logic     bubble_dx;
    logic     md_wb;
    reg_idx_t md_wb_rd;
    logic     md_err;
    logic     md_busy;

    modport master (
        output fd_rs, fd_rt, fd_uses_rt, dx_rd, dx_is_lw, dx_is_mult,
               dx_is_div, flush, md_rdy, md_exc,
        input  ctrl_mult, ctrl_div, stall_pc_fd, stall_dx, bubble_xm,
               bubble_dx, md_wb, md_wb_rd, md_err, md_busy
    );

    modport slave (
        input  fd_rs, fd_rt, fd_uses_rt, dx_rd, dx_is_lw, dx_is_mult,
               dx_is_div, flush, md_rdy, md_exc,
        output ctrl_mult, ctrl_div, stall_pc_fd, stall_dx, bubble_xm,
               bubble_dx, md_wb, md_wb_rd, md_err, md_busy
    );

endinterface

// File: rtl/multdiv_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator.
// A lw in DX whose destination is read by the instruction in FD cannot be
// forwarded in time, so the consumer must wait one cycle.
// Ports:
//   fd_rs_i, fd_rt_i, fd_uses_rt_i : sources of the FD instruction
//   dx_rd_i, dx_is_lw_i            : destination/type of the DX instruction
//   load_use_o                     : hazard present (flush not considered here)
module multdiv_stall_ctrl_hazard_detect
    import multdiv_stall_ctrl_pkg::*;
(
    input  reg_idx_t fd_rs_i,
    input  reg_idx_t fd_rt_i,
    input  logic     fd_uses_rt_i,
    input  reg_idx_t dx_rd_i,
    input  logic     dx_is_lw_i,
    output logic     load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (dx_rd_i == fd_rs_i);
    assign rt_match = fd_uses_rt_i & (dx_rd_i == fd_rt_i);

    // r0 is hardwired to zero, so a lw targeting it never produces a hazard.
    assign load_use_o = dx_is_lw_i & (dx_rd_i != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/multdiv_stall_ctrl.sv
// Multdiv sequencer and stall controller for the X stage.
// Starts the multicycle multiplier/divider when a mult/div reaches DX, freezes
// PC/FD/DX and bubbles XM while the unit runs, then selects the multdiv result
// into XM for one cycle. It also stalls on load-use hazards that forwarding
// cannot cover.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset; every output reads 0 while it is low
//   bus     : slave side of multdiv_stall_ctrl_if (decode fields, flush, unit
//             handshake in; start pulses, freeze/bubble controls, write-back
//             select, latched destination, error and busy out)
module multdiv_stall_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multdiv_stall_ctrl_if.slave  bus
);
    import multdiv_stall_ctrl_pkg::*;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    reg_idx_t         rd_q, rd_d;
    logic             err_q, err_d;

    logic load_use;
    logic lu_eff;
    logic md_start;

    logic ctrl_mult_c;
    logic ctrl_div_c;
    logic stall_pc_fd_c;
    logic stall_dx_c;
    logic bubble_xm_c;
    logic bubble_dx_c;
    logic md_wb_c;
    logic md_err_c;

    multdiv_stall_ctrl_hazard_detect u_hazard (
        .fd_rs_i      (bus.fd_rs),
        .fd_rt_i      (bus.fd_rt),
        .fd_uses_rt_i (bus.fd_uses_rt),
        .dx_rd_i      (bus.dx_rd),
        .dx_is_lw_i   (bus.dx_is_lw),
        .load_use_o   (load_use)
    );

    // A flush squashes DX, so neither a pending start nor a load-use consumer
    // relationship survives it.
    assign md_start = (bus.dx_is_mult | bus.dx_is_div) & ~bus.flush;
    assign lu_eff   = load_use & ~bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= REG_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        err_d         = err_q;
        ctrl_mult_c   = 1'b0;
        ctrl_div_c    = 1'b0;
        stall_pc_fd_c = 1'b0;
        stall_dx_c    = 1'b0;
        bubble_xm_c   = 1'b0;
        bubble_dx_c   = 1'b0;
        md_wb_c       = 1'b0;
        md_err_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    // Mult takes priority if decode ever flags both.
                    ctrl_mult_c   = bus.dx_is_mult;
                    ctrl_div_c    = bus.dx_is_div & ~bus.dx_is_mult;
                    stall_pc_fd_c = 1'b1;
                    stall_dx_c    = 1'b1;
                    bubble_xm_c   = 1'b1;
                    rd_d          = bus.dx_rd;
                    cnt_d         = '0;
                    err_d         = 1'b0;
                    state_d       = ST_BUSY;
                end else if (lu_eff) begin
                    stall_pc_fd_c = 1'b1;
                    bubble_dx_c   = 1'b1;
                end
            end

            ST_BUSY: begin
                stall_pc_fd_c = 1'b1;
                stall_dx_c    = 1'b1;
                bubble_xm_c   = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                // A result arriving on the timeout cycle still counts as a
                // normal completion, so md_rdy is tested first.
                if (bus.md_rdy) begin
                    err_d   = bus.md_exc;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // The md instruction moves DX->XM now; the DX slot is refilled
                // with a nop while FD waits only if a load-use also holds.
                md_wb_c       = 1'b1;
                md_err_c      = err_q;
                bubble_dx_c   = 1'b1;
                stall_pc_fd_c = lu_eff;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational controls are forced low while reset is held so the
    // pipeline sees a quiet controller even with live decode inputs.
    assign bus.ctrl_mult   = ctrl_mult_c   & reset_n;
    assign bus.ctrl_div    = ctrl_div_c    & reset_n;
    assign bus.stall_pc_fd = stall_pc_fd_c & reset_n;
    assign bus.stall_dx    = stall_dx_c    & reset_n;
    assign bus.bubble_xm   = bubble_xm_c   & reset_n;
    assign bus.bubble_dx   = bubble_dx_c   & reset_n;
    assign bus.md_wb       = md_wb_c       & reset_n;
    assign bus.md_err      = md_err_c      & reset_n;
    assign bus.md_wb_rd    = rd_q;
    assign bus.md_busy     = (state_q != ST_IDLE) & reset_n;

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl with a cycle-level reference model.
module tb_multdiv_stall_ctrl;

    localparam int TIMEOUT = 40;

    logic clock;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    multdiv_stall_ctrl_if bus ();

    multdiv_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_busy_n: BUSY cycles already spent by the op in flight (-1 = none).
    // m_done  : this cycle is the write-back cycle.
    int         m_busy_n = -1, n_busy_n = -1;
    bit         m_done = 0, n_done = 0;
    bit         m_err = 0, n_err = 0;
    logic [4:0] m_rd = 0, n_rd = 0;

    bit         e_cm, e_cd, e_spf, e_sdx, e_bxm, e_bdx, e_wb, e_err, e_busy;
    logic [4:0] e_rd;
    bit         lu, start;

    always @(negedge clock) begin
        {e_cm, e_cd, e_spf, e_sdx, e_bxm, e_bdx, e_wb, e_err, e_busy} = '0;
        e_rd     = m_rd;
        n_busy_n = m_busy_n;
        n_done   = 1'b0;
        n_err    = m_err;
        n_rd     = m_rd;
        if (!reset_n) begin
            e_rd     = 5'd0;
            n_busy_n = -1;
            n_err    = 1'b0;
            n_rd     = 5'd0;
        end else begin
            lu = bus.dx_is_lw && bus.dx_rd != 5'd0 &&
                 (bus.dx_rd == bus.fd_rs || (bus.fd_uses_rt && bus.dx_rd == bus.fd_rt)) &&
                 !bus.flush;
            start = (bus.dx_is_mult || bus.dx_is_div) && !bus.flush;
            if (m_done) begin
                e_wb = 1; e_err = m_err; e_bdx = 1; e_spf = lu; e_busy = 1;
                n_busy_n = -1;
            end else if (m_busy_n >= 0) begin
                e_spf = 1; e_sdx = 1; e_bxm = 1; e_busy = 1;
                if (bus.md_rdy) begin
                    n_done = 1; n_err = bus.md_exc; n_busy_n = -1;
                end else if (m_busy_n == TIMEOUT - 1) begin
                    n_done = 1; n_err = 1; n_busy_n = -1;
                end else begin
                    n_busy_n = m_busy_n + 1;
                end
            end else if (start) begin
                e_cm = bus.dx_is_mult;
                e_cd = bus.dx_is_div && !bus.dx_is_mult;
                e_spf = 1; e_sdx = 1; e_bxm = 1;
                n_busy_n = 0;
                n_rd = bus.dx_rd;
            end else if (lu) begin
                e_spf = 1; e_bdx = 1;
            end
        end
        chk("cyc_ctrl_mult",   bus.ctrl_mult,   e_cm);
        chk("cyc_ctrl_div",    bus.ctrl_div,    e_cd);
        chk("cyc_stall_pc_fd", bus.stall_pc_fd, e_spf);
        chk("cyc_stall_dx",    bus.stall_dx,    e_sdx);
        chk("cyc_bubble_xm",   bus.bubble_xm,   e_bxm);
        chk("cyc_bubble_dx",   bus.bubble_dx,   e_bdx);
        chk("cyc_md_wb",       bus.md_wb,       e_wb);
        chk("cyc_md_err",      bus.md_err,      e_err);
        chk("cyc_md_busy",     bus.md_busy,     e_busy);
        chk("cyc_md_wb_rd",    bus.md_wb_rd,    e_rd);
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy_n <= -1; m_done <= 0; m_err <= 0; m_rd <= 0;
        end else begin
            m_busy_n <= n_busy_n; m_done <= n_done; m_err <= n_err; m_rd <= n_rd;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fd_rs = 0; bus.fd_rt = 0; bus.fd_uses_rt = 0; bus.dx_rd = 0;
        bus.dx_is_lw = 0; bus.dx_is_mult = 0; bus.dx_is_div = 0;
        bus.flush = 0; bus.md_rdy = 0; bus.md_exc = 0;
    endtask

    // Runs one multdiv op from its start cycle (c=0) to the write-back cycle.
    // md_rdy pulses in cycle rdy_at (-1 = never). DX stays frozen on the op.
    task automatic md_op(input bit is_mult, input bit is_div, input logic [4:0] rd,
                         input int rdy_at, input bit exc,
                         output int stalls, output int busy, output int cm,
                         output int cd, output int wb, output bit err,
                         output logic [4:0] wb_rd);
        bit done = 0;
        stalls = 0; busy = 0; cm = 0; cd = 0; wb = 0; err = 0; wb_rd = 0;
        bus.dx_is_mult = is_mult; bus.dx_is_div = is_div; bus.dx_rd = rd;
        for (int c = 0; c < 80; c++) begin
            bus.md_rdy = (c == rdy_at);
            bus.md_exc = (c == rdy_at) && exc;
            @(negedge clock);
            if (bus.stall_pc_fd) stalls++;
            if (bus.md_busy)     busy++;
            if (bus.ctrl_mult)   cm++;
            if (bus.ctrl_div)    cd++;
            if (bus.md_wb) begin
                wb++; err = bus.md_err; wb_rd = bus.md_wb_rd; done = 1;
            end
            step();
            if (done) break;
        end
        if (!done) begin
            errors++;
            $display("FAIL md_op_wait actual=no_md_wb required=md_wb within 80 cycles");
        end
        clear_inputs();
    endtask

    typedef struct {
        bit lw; logic [4:0] rd; logic [4:0] rs; logic [4:0] rt; bit uses_rt; bit flush; bit exp;
    } lu_vec_t;

    initial begin
        int stalls, busy, cm, cd, wb;
        bit err;
        logic [4:0] wb_rd;
        lu_vec_t lv[7];

        reset_n = 1'b1;
        clear_inputs();
        #1 reset_n = 1'b0;
        // decode looks like a load-use while reset is held: outputs stay 0
        bus.dx_is_lw = 1; bus.dx_rd = 5; bus.fd_rs = 5;
        #2;
        chk("rst_stall_pc_fd", bus.stall_pc_fd, 0);
        chk("rst_bubble_dx",   bus.bubble_dx,   0);
        chk("rst_md_busy",     bus.md_busy,     0);
        chk("rst_md_wb_rd",    bus.md_wb_rd,    0);
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        step();

        // load-use table in IDLE
        lv[0] = '{1, 5, 5, 0, 0, 0, 1};
        lv[1] = '{1, 5, 0, 5, 1, 0, 1};
        lv[2] = '{1, 5, 0, 5, 0, 0, 0};
        lv[3] = '{1, 0, 0, 0, 1, 0, 0};
        lv[4] = '{0, 5, 5, 5, 1, 0, 0};
        lv[5] = '{1, 5, 5, 0, 0, 1, 0};
        lv[6] = '{1, 7, 3, 4, 1, 0, 0};
        foreach (lv[i]) begin
            bus.dx_is_lw = lv[i].lw; bus.dx_rd = lv[i].rd; bus.fd_rs = lv[i].rs;
            bus.fd_rt = lv[i].rt; bus.fd_uses_rt = lv[i].uses_rt; bus.flush = lv[i].flush;
            @(negedge clock);
            chk("lu_stall_pc_fd", bus.stall_pc_fd, lv[i].exp);
            chk("lu_bubble_dx",   bus.bubble_dx,   lv[i].exp);
            chk("lu_stall_dx",    bus.stall_dx,    0);
            step();
            clear_inputs();
            chk("lu_no_state",    bus.md_busy,     0);
        end

        // mult killed by flush
        bus.dx_is_mult = 1; bus.dx_rd = 9; bus.flush = 1;
        @(negedge clock);
        chk("flush_ctrl_mult", bus.ctrl_mult, 0);
        chk("flush_stall",     bus.stall_pc_fd, 0);
        step();
        clear_inputs();
        chk("flush_idle", bus.md_busy, 0);

        // mult, md_rdy 17 cycles after start
        md_op(1, 0, 9, 17, 0, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("mult_stalls", stalls, 18);
        chk("mult_busy",   busy,   18);
        chk("mult_cm",     cm,     1);
        chk("mult_cd",     cd,     0);
        chk("mult_wb",     wb,     1);
        chk("mult_err",    err,    0);
        chk("mult_rd",     wb_rd,  9);
        chk("mult_idle",   bus.md_busy, 0);

        // div by zero
        md_op(0, 1, 4, 5, 1, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("dbz_cd",  cd,    1);
        chk("dbz_cm",  cm,    0);
        chk("dbz_err", err,   1);
        chk("dbz_rd",  wb_rd, 4);

        // both flags: mult wins
        md_op(1, 1, 6, 2, 0, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("both_cm", cm, 1);
        chk("both_cd", cd, 0);

        // timeout, then a late md_rdy
        md_op(0, 1, 20, -1, 0, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("to_stalls", stalls, 41);
        chk("to_busy",   busy,   41);
        chk("to_err",    err,    1);
        bus.md_rdy = 1;
        @(negedge clock);
        chk("late_rdy_busy", bus.md_busy, 0);
        chk("late_rdy_wb",   bus.md_wb,   0);
        step();
        bus.md_rdy = 0;
        chk("late_rdy_idle", bus.md_busy, 0);

        // md_rdy on the timeout cycle wins
        md_op(1, 0, 21, 40, 0, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("tie_stalls", stalls, 41);
        chk("tie_err",    err,    0);

        // reset mid-BUSY
        bus.dx_is_mult = 1; bus.dx_rd = 12;
        step();
        repeat (5) step();
        chk("pre_rst_busy", bus.md_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_stall_pc_fd", bus.stall_pc_fd, 0);
        chk("arst_stall_dx",    bus.stall_dx,    0);
        chk("arst_bubble_xm",   bus.bubble_xm,   0);
        chk("arst_md_busy",     bus.md_busy,     0);
        chk("arst_md_wb_rd",    bus.md_wb_rd,    0);
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
        bus.md_rdy = 1;
        @(negedge clock);
        chk("post_rst_wb", bus.md_wb, 0);
        step();
        bus.md_rdy = 0;
        chk("post_rst_busy", bus.md_busy, 0);
        md_op(1, 0, 3, 3, 0, stalls, busy, cm, cd, wb, err, wb_rd);
        chk("restart_stalls", stalls, 4);
        chk("restart_wb",     wb,     1);
        chk("restart_rd",     wb_rd,  3);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
